// File: rtl/ramb_arb_pkg.sv
`default_nettype none
// ============================================================================
// ramb_arb_pkg : shared constants and types for the SB_RAM40_4K 256x16 arbiter
// Revision     : 1.0
// ============================================================================
package ramb_arb_pkg;

  localparam int RAM_ADDR_BITS     = 11;
  localparam int RAM_DATA_BITS     = 16;
  localparam int READ_MODE_256X16  = 0;
  localparam int WRITE_MODE_256X16 = 0;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  typedef enum logic [0:0] {
    SIDE_A = 1'b0,
    SIDE_B = 1'b1
  } side_e;

  function automatic side_e other_side(input side_e s);
    return (s == SIDE_A) ? SIDE_B : SIDE_A;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ramb_arb_rr.sv
`default_nettype none
// ============================================================================
// ramb_arb_rr : 2-way round-robin picker; priority passes to the loser of a conflict
// Revision    : 1.0
// ============================================================================
module ramb_arb_rr
  import ramb_arb_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  req_a_i,
  input  logic  req_b_i,
  input  logic  conflict_i,
  output logic  gnt_a_o,
  output logic  gnt_b_o,
  output side_e prio_o
);

  side_e prio_q, prio_d;

  always_comb begin
    prio_d = conflict_i ? other_side(prio_q) : prio_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prio_q <= SIDE_A;
    end else begin
      prio_q <= prio_d;
    end
  end

  assign gnt_a_o = req_a_i && (!conflict_i || (prio_q == SIDE_A));
  assign gnt_b_o = req_b_i && (!conflict_i || (prio_q == SIDE_B));
  assign prio_o  = prio_q;

endmodule
`default_nettype wire

// File: rtl/ramb_arbiter.sv
`default_nettype none
// ============================================================================
// ramb_arbiter : shares one SB_RAM40_4K (256x16) between requesters A and B;
//                define RAMB_ARB_CLEAR_EN to zero-fill the RAM after reset.
// Revision     : 1.0
// ============================================================================
module ramb_arbiter
  import ramb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                     CLKIN,
  input  logic                     RESETN,
  input  logic                     A_VALID,
  output logic                     A_READY,
  input  logic                     A_WE,
  input  logic [ADDR_WIDTH-1:0]    A_ADDR,
  input  logic [DATA_WIDTH-1:0]    A_WDATA,
  output logic                     A_RVALID,
  output logic [DATA_WIDTH-1:0]    A_RDATA,
  input  logic                     B_VALID,
  output logic                     B_READY,
  input  logic                     B_WE,
  input  logic [ADDR_WIDTH-1:0]    B_ADDR,
  input  logic [DATA_WIDTH-1:0]    B_WDATA,
  output logic                     B_RVALID,
  output logic [DATA_WIDTH-1:0]    B_RDATA,
  output logic [RAM_ADDR_BITS-1:0] RAM_RADDR,
  output logic [RAM_ADDR_BITS-1:0] RAM_WADDR,
  output logic [RAM_DATA_BITS-1:0] RAM_WDATA,
  output logic [RAM_DATA_BITS-1:0] RAM_MASK,
  output logic                     RAM_WE,
  output logic                     RAM_RE,
  input  logic [RAM_DATA_BITS-1:0] RAM_RDATA,
  output logic                     BUSY
);

  if (DATA_WIDTH != RAM_DATA_BITS || ADDR_WIDTH < 1 || ADDR_WIDTH > 8) begin : g_param_check
    $error("ramb_arbiter: DATA_WIDTH must be 16 and ADDR_WIDTH 1..8");
  end

  state_e                  state_q, state_d;
  logic                    clr_done;
  logic [ADDR_WIDTH-1:0]   clr_addr;

`ifdef RAMB_ARB_CLEAR_EN
  localparam state_e RESET_STATE = CLEAR;

  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;

  always_comb begin
    clr_cnt_d = (state_q == CLEAR) ? clr_cnt_q + ADDR_WIDTH'(1) : '0;
  end

  always_ff @(posedge CLKIN) begin
    if (!RESETN) begin
      clr_cnt_q <= '0;
    end else begin
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign clr_done = &clr_cnt_q;
  assign clr_addr = clr_cnt_q;
  assign BUSY     = (state_q == CLEAR);
`else
  localparam state_e RESET_STATE = RUN;

  assign clr_done = 1'b1;
  assign clr_addr = '0;
  assign BUSY     = 1'b0;
`endif

  always_ff @(posedge CLKIN) begin
    if (!RESETN) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   if (clr_done) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = RESET_STATE;
    endcase
  end

  logic  run, a_req, b_req, conflict, rw_same_addr;
  logic  gnt_a, gnt_b;
  logic  rd_a, rd_b, wr_a, wr_b;
  side_e prio;

  assign run      = RESETN && (state_q == RUN);
  assign a_req    = A_VALID && run;
  assign b_req    = B_VALID && run;
  assign conflict = a_req && b_req && (A_WE == B_WE);

  ramb_arb_rr u_rr (
    .clk_i      (CLKIN),
    .rst_ni     (RESETN),
    .req_a_i    (a_req),
    .req_b_i    (b_req),
    .conflict_i (conflict),
    .gnt_a_o    (gnt_a),
    .gnt_b_o    (gnt_b),
    .prio_o     (prio)
  );

  // A read colliding with a same-address write waits so it observes the new word.
  assign rw_same_addr = a_req && b_req && (A_WE != B_WE) && (A_ADDR == B_ADDR);

  assign A_READY = gnt_a && !(rw_same_addr && !A_WE);
  assign B_READY = gnt_b && !(rw_same_addr && !B_WE);

  assign rd_a = A_READY && !A_WE;
  assign rd_b = B_READY && !B_WE;
  assign wr_a = A_READY &&  A_WE;
  assign wr_b = B_READY &&  B_WE;

  always_comb begin
    RAM_RE    = 1'b0;
    RAM_WE    = 1'b0;
    RAM_RADDR = '0;
    RAM_WADDR = '0;
    RAM_WDATA = '0;
    if (RESETN && (state_q == CLEAR)) begin
      RAM_WE                     = 1'b1;
      RAM_WADDR[ADDR_WIDTH-1:0]  = clr_addr;
    end else begin
      if (rd_a) begin
        RAM_RE                    = 1'b1;
        RAM_RADDR[ADDR_WIDTH-1:0] = A_ADDR;
      end else if (rd_b) begin
        RAM_RE                    = 1'b1;
        RAM_RADDR[ADDR_WIDTH-1:0] = B_ADDR;
      end
      if (wr_a) begin
        RAM_WE                    = 1'b1;
        RAM_WADDR[ADDR_WIDTH-1:0] = A_ADDR;
        RAM_WDATA                 = A_WDATA;
      end else if (wr_b) begin
        RAM_WE                    = 1'b1;
        RAM_WADDR[ADDR_WIDTH-1:0] = B_ADDR;
        RAM_WDATA                 = B_WDATA;
      end
    end
  end

  assign RAM_MASK = '0;

  logic a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;

  assign a_rvalid_d = rd_a;
  assign b_rvalid_d = rd_b;

  always_ff @(posedge CLKIN) begin
    if (!RESETN) begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
    end
  end

  // Gating with RESETN drops a response whose cycle coincides with reset.
  assign A_RVALID = a_rvalid_q && RESETN;
  assign B_RVALID = b_rvalid_q && RESETN;
  assign A_RDATA  = RAM_RDATA;
  assign B_RDATA  = RAM_RDATA;

  a_conflict_follows_prio : assert property (@(posedge CLKIN) disable iff (!RESETN)
    conflict |-> (gnt_a == (prio == SIDE_A)));

endmodule
`default_nettype wire

// File: tb/tb_ramb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_ramb_arbiter : scoreboard bench for ramb_arbiter with a behavioural RAM model
// Revision        : 1.0
// ============================================================================
module tb_ramb_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        RESETN;
  logic        A_VALID, A_READY, A_WE, A_RVALID;
  logic [7:0]  A_ADDR;
  logic [15:0] A_WDATA, A_RDATA;
  logic        B_VALID, B_READY, B_WE, B_RVALID;
  logic [7:0]  B_ADDR;
  logic [15:0] B_WDATA, B_RDATA;
  logic [10:0] RAM_RADDR, RAM_WADDR;
  logic [15:0] RAM_WDATA, RAM_MASK, RAM_RDATA;
  logic        RAM_WE, RAM_RE, BUSY;

  ramb_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) dut (
    .CLKIN(clk), .RESETN(RESETN),
    .A_VALID(A_VALID), .A_READY(A_READY), .A_WE(A_WE), .A_ADDR(A_ADDR),
    .A_WDATA(A_WDATA), .A_RVALID(A_RVALID), .A_RDATA(A_RDATA),
    .B_VALID(B_VALID), .B_READY(B_READY), .B_WE(B_WE), .B_ADDR(B_ADDR),
    .B_WDATA(B_WDATA), .B_RVALID(B_RVALID), .B_RDATA(B_RDATA),
    .RAM_RADDR(RAM_RADDR), .RAM_WADDR(RAM_WADDR), .RAM_WDATA(RAM_WDATA),
    .RAM_MASK(RAM_MASK), .RAM_WE(RAM_WE), .RAM_RE(RAM_RE),
    .RAM_RDATA(RAM_RDATA), .BUSY(BUSY)
  );

  function automatic logic [15:0] init_word(input int i);
    return 16'(i * 257) ^ 16'h5AC3;
  endfunction

  // SB_RAM40_4K stand-in: registered read, old data on the read port.
  logic [15:0] ram [256];
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = init_word(i);
    RAM_RDATA <= '0;
    forever begin
      @(posedge clk);
      if (RAM_RE) RAM_RDATA <= ram[RAM_RADDR[7:0]];
      if (RAM_WE) ram[RAM_WADDR[7:0]] = RAM_WDATA & ~RAM_MASK;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0, n_total = 0;

  typedef struct {
    int          due;
    logic [15:0] data;
  } exp_t;
  exp_t qa[$], qb[$];

  logic [15:0] ref_mem [256];
  bit          prio_b;
  bit          a_pend, b_pend;
  logic        a_we, b_we;
  logic [7:0]  a_addr, b_addr;
  logic [15:0] a_wd, b_wd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic req_a(input logic we, input logic [7:0] addr, input logic [15:0] wd);
    a_pend = 1'b1; a_we = we; a_addr = addr; a_wd = wd;
  endtask

  task automatic req_b(input logic we, input logic [7:0] addr, input logic [15:0] wd);
    b_pend = 1'b1; b_we = we; b_addr = addr; b_wd = wd;
  endtask

  // One clock: drive held requests, predict grants from the arbitration rules, update the model.
  task automatic cycle();
    bit ea, eb, acc_a, acc_b;
    @(negedge clk);
    A_VALID = a_pend; A_WE = a_we; A_ADDR = a_addr; A_WDATA = a_wd;
    B_VALID = b_pend; B_WE = b_we; B_ADDR = b_addr; B_WDATA = b_wd;
    #1;
    ea = 1'b0; eb = 1'b0;
    if (a_pend && !b_pend) ea = 1'b1;
    else if (b_pend && !a_pend) eb = 1'b1;
    else if (a_pend && b_pend) begin
      if (a_we != b_we) begin
        ea = a_we || (a_addr != b_addr);
        eb = b_we || (a_addr != b_addr);
      end else begin
        ea = !prio_b;
        eb = prio_b;
      end
    end
    chk("a_ready", A_READY, ea);
    chk("b_ready", B_READY, eb);
    acc_a = a_pend && A_READY;
    acc_b = b_pend && B_READY;
    chk("ram_re", RAM_RE, (acc_a && !a_we) || (acc_b && !b_we));
    chk("ram_we", RAM_WE, (acc_a && a_we) || (acc_b && b_we));
    chk("ram_hi_bits_mask", {RAM_RADDR[10:8], RAM_WADDR[10:8], RAM_MASK}, 0);
    if (acc_a && !a_we) begin
      chk("ram_raddr_a", RAM_RADDR, {3'b000, a_addr});
      qa.push_back('{due: cyc + 1, data: ref_mem[a_addr]});
    end
    if (acc_b && !b_we) begin
      chk("ram_raddr_b", RAM_RADDR, {3'b000, b_addr});
      qb.push_back('{due: cyc + 1, data: ref_mem[b_addr]});
    end
    if (acc_a && a_we) begin
      chk("ram_wdata_a", {RAM_WADDR, RAM_WDATA}, {3'b000, a_addr, a_wd});
      ref_mem[a_addr] = a_wd;
    end
    if (acc_b && b_we) begin
      chk("ram_wdata_b", {RAM_WADDR, RAM_WDATA}, {3'b000, b_addr, b_wd});
      ref_mem[b_addr] = b_wd;
    end
    if (a_pend && b_pend && (a_we == b_we)) prio_b = !prio_b;
    if (acc_a) a_pend = 1'b0;
    if (acc_b) b_pend = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while ((a_pend || b_pend) && n < max_cycles) begin
      cycle();
      n++;
    end
    if (a_pend || b_pend) begin
      chk("drain_timeout", {a_pend, b_pend}, 0);
      a_pend = 1'b0; b_pend = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

`ifdef RAMB_ARB_CLEAR_EN
  // Entered just after RESETN rises; counts BUSY cycles and checks the sweep address.
  task automatic sweep(input int restart_at);
    int  n = 0;
    bit  done = 1'b0;
    A_VALID = 1'b1; A_WE = 1'b0; A_ADDR = 8'hFF;
    B_VALID = 1'b1; B_WE = 1'b1; B_ADDR = 8'h00; B_WDATA = 16'hFFFF;
    for (int k = 0; k < 1200 && !done; k++) begin
      if (k > 0) @(negedge clk);
      if (restart_at > 0 && n == restart_at) begin
        RESETN = 1'b0;
        @(negedge clk);
        RESETN = 1'b1;
        n = 0;
        restart_at = 0;
      end
      #1;
      if (BUSY) begin
        chk("sweep_ready", {A_READY, B_READY, RAM_RE, RAM_WE}, 4'b0001);
        chk("sweep_waddr", RAM_WADDR, n);
        n++;
      end else begin
        done = 1'b1;
        A_VALID = 1'b0;
        B_VALID = 1'b0;
      end
    end
    chk("sweep_len", n, 256);
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
  endtask
`endif

  task automatic do_reset(input int restart_at);
    @(negedge clk);
    RESETN = 1'b0;
    a_pend = 1'b0; b_pend = 1'b0;
    qa.delete(); qb.delete();
    prio_b = 1'b0;
    A_VALID = 1'b1; A_WE = 1'b0; B_VALID = 1'b1; B_WE = 1'b1;
    #1;
    chk("reset_quiet", {A_READY, B_READY, A_RVALID, B_RVALID, RAM_WE, RAM_RE}, 0);
    @(negedge clk);
    A_VALID = 1'b0; B_VALID = 1'b0;
    RESETN = 1'b1;
`ifdef RAMB_ARB_CLEAR_EN
    sweep(restart_at);
`else
    #1;
    chk("busy_tied_low", {BUSY, 31'(restart_at)}, 0);
`endif
  endtask

  task automatic mon(input bit side);
    logic        rv;
    logic [15:0] rd;
    exp_t        e;
    bit          have;
    rv   = side ? B_RVALID : A_RVALID;
    rd   = side ? B_RDATA  : A_RDATA;
    have = side ? (qb.size() > 0 && qb[0].due == cyc) : (qa.size() > 0 && qa[0].due == cyc);
    if (have) begin
      e = side ? qb.pop_front() : qa.pop_front();
      chk(side ? "b_rvalid" : "a_rvalid", rv, 1);
      if (rv) chk(side ? "b_rdata" : "a_rdata", rd, e.data);
    end else if (rv) begin
      chk(side ? "b_spurious_rvalid" : "a_spurious_rvalid", rv, 0);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      mon(1'b0);
      mon(1'b1);
    end
  end

  initial begin
    RESETN = 1'b0;
    A_VALID = 1'b0; A_WE = 1'b0; A_ADDR = '0; A_WDATA = '0;
    B_VALID = 1'b0; B_WE = 1'b0; B_ADDR = '0; B_WDATA = '0;
    a_pend = 1'b0; b_pend = 1'b0; prio_b = 1'b0;
    a_we = 1'b0; b_we = 1'b0; a_addr = '0; b_addr = '0; a_wd = '0; b_wd = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

    do_reset(0);

    // write then read back on A; also read the top word
    req_a(1'b1, 8'h05, 16'h1234); drain(10);
    req_a(1'b0, 8'h05, 16'h0);    drain(10);
    req_a(1'b0, 8'hFF, 16'h0);    drain(10);
    idle(3);

    // read and write to different addresses share one cycle
    req_a(1'b0, 8'h10, 16'h0); req_b(1'b1, 8'h20, 16'hBEEF); drain(10);
    idle(2);

    // same-address read/write: write first, read sees new data
    req_a(1'b0, 8'h30, 16'h0); req_b(1'b1, 8'h30, 16'h5A5A); drain(10);
    idle(2);

    // continuous read contention alternates
    for (int k = 0; k < 4; k++) begin
      if (!a_pend) req_a(1'b0, 8'(8'h40 + k), 16'h0);
      if (!b_pend) req_b(1'b0, 8'(8'h50 + k), 16'h0);
      cycle();
    end
    drain(10);
    idle(2);

    // reset right after a read accept drops its response
    req_a(1'b0, 8'h05, 16'h0); cycle();
    do_reset(0);
    req_a(1'b0, 8'h06, 16'h0); req_b(1'b0, 8'h07, 16'h0); drain(10);
    idle(2);

    for (int k = 0; k < 400; k++) begin
      if (!a_pend && $urandom_range(0, 3) != 0)
        req_a(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 16'($urandom));
      if (!b_pend && $urandom_range(0, 3) != 0)
        req_b(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 16'($urandom));
      cycle();
    end
    drain(50);
    idle(3);
    chk("queues_empty", qa.size() + qb.size(), 0);

`ifdef RAMB_ARB_CLEAR_EN
    do_reset(100);
    req_a(1'b0, 8'h0F, 16'h0); req_b(1'b0, 8'h05, 16'h0); drain(10);
    idle(3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
